pipelined_carry_select_adder: RTL

Parametrised, pipelined successor to the single-cycle carry-select adder. Splits the DATA_WIDTH-bit carry-select chain into PIPE_STAGES register-separated segments and adds a subtract mode, a signed overflow flag and a valid/ready handshake with backpressure. Sits in the integer adders library as the throughput-oriented adder for multi-cycle datapaths (ALU, MAC accumulators).

---
 rtl/pipelined_carry_select_adder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready handshake.
// Each pipeline stage resolves BLOCKS_PER_STAGE carry-select blocks and passes the carry forward.
module pipelined_carry_select_adder #(
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_WIDTH = 4,
    parameter int PIPE_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] operand_A_i,
    input  logic [DATA_WIDTH-1:0] operand_B_i,
    input  logic                  carry_i,
    input  logic                  sub_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  carry_o,
    output logic                  overflow_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    localparam int CSA_BLOCKS = DATA_WIDTH / BLOCK_WIDTH;
    localparam int BPS        = CSA_BLOCKS / PIPE_STAGES;
    localparam int SW         = BPS * BLOCK_WIDTH;

    logic advance;

    // The whole pipeline moves as one unit; bubbles are not squeezed out.
    assign advance = ~valid_o | ready_i;
    assign ready_o = advance;

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        localparam int LO = s * SW;
        localparam int HW = DATA_WIDTH - LO;

        logic [HW-1:0]      a_in;
        logic [HW-1:0]      b_in;
        logic               c_in;
        logic               sub_in;
        logic               v_in;
        logic [SW-1:0]      sum;
        logic               c_out;
        logic [LO+SW-1:0]   res_d;

        if (s == 0) begin : g_src
            assign a_in   = operand_A_i;
            assign b_in   = sub_i ? ~operand_B_i : operand_B_i;
            assign c_in   = carry_i ^ sub_i;
            assign sub_in = sub_i;
            assign v_in   = valid_i;
            assign res_d  = sum;
        end else begin : g_src
            assign a_in   = g_stage[s-1].g_mid.a_q;
            assign b_in   = g_stage[s-1].g_mid.b_q;
            assign c_in   = g_stage[s-1].g_mid.c_q;
            assign sub_in = g_stage[s-1].g_mid.sub_q;
            assign v_in   = g_stage[s-1].g_mid.v_q;
            assign res_d  = {sum, g_stage[s-1].g_mid.res_q};
        end

        always_comb begin
            logic [BLOCK_WIDTH:0] r0;
            logic [BLOCK_WIDTH:0] r1;
            logic [BLOCK_WIDTH:0] pick;
            logic                 carry;
            // NOTE: every variable gets a default before any branch so no latch is inferred.
            r0    = '0;
            r1    = '0;
            pick  = '0;
            carry = c_in;
            sum   = '0;
            for (int k = 0; k < BPS; k++) begin
                r0 = {1'b0, a_in[k*BLOCK_WIDTH +: BLOCK_WIDTH]}
                   + {1'b0, b_in[k*BLOCK_WIDTH +: BLOCK_WIDTH]};
                r1 = r0 + (BLOCK_WIDTH+1)'(1);
                // Block 0 has a known carry-in, so it ripples instead of selecting.
                if (s == 0 && k == 0) pick = r0 + {{BLOCK_WIDTH{1'b0}}, carry};
                else                  pick = carry ? r1 : r0;
                sum[k*BLOCK_WIDTH +: BLOCK_WIDTH] = pick[BLOCK_WIDTH-1:0];
                carry = pick[BLOCK_WIDTH];
            end
            c_out = carry;
        end

        if (s < PIPE_STAGES - 1) begin : g_mid
            logic [HW-SW-1:0] a_q;
            logic [HW-SW-1:0] b_q;
            logic [LO+SW-1:0] res_q;
            logic             c_q;
            logic             sub_q;
            logic             v_q;

            // NOTE: data registers are reset too, so outputs are defined zeros after reset.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    res_q <= '0;
                    c_q   <= 1'b0;
                    sub_q <= 1'b0;
                    v_q   <= 1'b0;
                end else if (advance) begin
                    // NOTE: non-blocking assignments so every stage samples the pre-edge value of its predecessor.
                    a_q   <= a_in[HW-1:SW];
                    b_q   <= b_in[HW-1:SW];
                    res_q <= res_d;
                    c_q   <= c_out;
                    sub_q <= sub_in;
                    v_q   <= v_in;
                end
            end
        end else begin : g_last
            logic [DATA_WIDTH-1:0] res_q;
            logic                  co_q;
            logic                  ovf_q;
            logic                  v_q;

            // Sign bits of A and B_eff travel as the MSBs of the remaining operand slices.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    res_q <= '0;
                    co_q  <= 1'b0;
                    ovf_q <= 1'b0;
                    v_q   <= 1'b0;
                end else if (advance) begin
                    res_q <= res_d;
                    co_q  <= sub_in ? ~c_out : c_out;
                    ovf_q <= (a_in[HW-1] == b_in[HW-1]) && (sum[SW-1] != a_in[HW-1]);
                    v_q   <= v_in;
                end
            end
        end
    end

    assign result_o   = g_stage[PIPE_STAGES-1].g_last.res_q;
    assign carry_o    = g_stage[PIPE_STAGES-1].g_last.co_q;
    assign overflow_o = g_stage[PIPE_STAGES-1].g_last.ovf_q;
    assign valid_o    = g_stage[PIPE_STAGES-1].g_last.v_q;

endmodule
